// File: rtl/cr_xp10_decomp_htf_hist_builder.sv
// XP10 htf code-length histogram builder: counts symbols per code length for one Huffman table.
// Optional Kraft oversubscription check enabled by CR_XP10_DECOMP_HTF_KRAFT_CHECK_EN.
module cr_xp10_decomp_htf_hist_builder #(
  parameter  int MAX_DEPTH = 27,
  parameter  int WIDTH     = 10,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cl_valid,
  output logic                           cl_ready,
  input  logic [DW-1:0]                  cl_data,
  input  logic                           cl_last,
  input  logic                           hist_release,
  output logic                           hist_complete,
  output logic [DW-1:0]                  hist_depth,
  output logic [MAX_DEPTH:1][WIDTH-1:0]  histogram,
  output logic                           hist_error,
  output logic [1:0]                     hist_error_code
);

  typedef enum logic [1:0] {ACCUM, HOLD, DRAIN, CLEAR} state_e;

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

  state_e                          state_q;
  logic [MAX_DEPTH:1][WIDTH-1:0]   hist_q;
  logic [DW-1:0]                   depth_q;
  logic                            beat;
  logic [DW-1:0]                   sel;
  logic                            len_ok;
  logic                            sat;
  logic [DW-1:0]                   depth_nxt;
  logic                            kraft_over;
  logic [1:0]                      err_code;

  assign beat       = cl_valid && cl_ready;
  assign histogram  = hist_q;
  assign hist_depth = depth_q;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel = cl_data;
    if (cl_data == '0 || cl_data > MAX_D) sel = DW'(1);
    len_ok    = (cl_data <= MAX_D);
    sat       = (cl_data != '0) && len_ok && (hist_q[sel] == '1);
    depth_nxt = (len_ok && cl_data > depth_q) ? cl_data : depth_q;
  end

`ifdef CR_XP10_DECOMP_HTF_KRAFT_CHECK_EN
  localparam int KW = MAX_DEPTH + 2;
  localparam logic [KW-1:0] KRAFT_ONE = KW'(1) << MAX_DEPTH;
  localparam logic [KW-1:0] KRAFT_SAT = KW'(1) << (MAX_DEPTH + 1);

  logic [KW-1:0] kraft_q, kraft_inc, kraft_sum, kraft_nxt;

  // Each length d contributes 2^(MAX_DEPTH-d); a complete prefix code sums to exactly KRAFT_ONE.
  always_comb begin
    kraft_inc = '0;
    if (cl_data != '0 && len_ok) kraft_inc = KRAFT_ONE >> sel;
    kraft_sum  = kraft_q + kraft_inc;
    kraft_nxt  = (kraft_sum > KRAFT_SAT) ? KRAFT_SAT : kraft_sum;
    kraft_over = kraft_nxt > KRAFT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kraft_q <= '0;
    end else if (state_q == CLEAR) begin
      kraft_q <= '0;
    end else if (state_q == ACCUM && beat && err_code == 2'd0) begin
      kraft_q <= kraft_nxt;
    end
  end
`else
  assign kraft_over = 1'b0;
`endif

  always_comb begin
    err_code = 2'd0;
    if (!len_ok)                                            err_code = 2'd1;
    else if (sat)                                           err_code = 2'd2;
    else if (cl_last && (depth_nxt == '0 || kraft_over))    err_code = 2'd3;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the histogram is a bank of flops, not a RAM, so resetting it is legal and cheap to reason about.
      state_q         <= ACCUM;
      cl_ready        <= 1'b1;
      hist_q          <= '0;
      depth_q         <= '0;
      hist_complete   <= 1'b0;
      hist_error      <= 1'b0;
      hist_error_code <= 2'd0;
    end else begin
      hist_complete <= 1'b0;
      hist_error    <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (beat) begin
            if (err_code != 2'd0) begin
              hist_error      <= 1'b1;
              hist_error_code <= err_code;
              state_q         <= cl_last ? CLEAR : DRAIN;
              cl_ready        <= !cl_last;
            end else begin
              if (cl_data != '0) begin
                hist_q[sel] <= hist_q[sel] + WIDTH'(1);
                depth_q     <= depth_nxt;
              end
              if (cl_last) begin
                hist_complete <= 1'b1;
                state_q       <= HOLD;
                cl_ready      <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (hist_release) state_q <= CLEAR;
        end
        DRAIN: begin
          if (beat && cl_last) begin
            state_q  <= CLEAR;
            cl_ready <= 1'b0;
          end
        end
        CLEAR: begin
          hist_q   <= '0;
          depth_q  <= '0;
          state_q  <= ACCUM;
          cl_ready <= 1'b1;
        end
        default: begin
          state_q  <= CLEAR;
          cl_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
